interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Interrupt controller that receives the single-cycle interrupt request pulses raised by the Timer, PPU, serial and joypad blocks. It holds IF (0xFF0F) and IE (0xFFFF) as a Bus_if peripheral and owns IME with the EI one-instruction delay. It signals pending and wake conditions to the CPU and resolves the dispatch vector through a start/resolve handshake, including the DMG cancel-to-0x0000 case.

## Interface
- No parameters.
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- bus  Bus_if.Peripheral_side  —  addr[15:0], wdata[7:0], rdata[7:0], read_en, write_en
- irq_bus  Interrupt_if.Controller_side  5  vblank_req, stat_req, timer_req, serial_req, joypad_req; single-cycle request pulses
- ime_ei  input  1  pulse: EI executed
- ime_di  input  1  pulse: DI executed
- ime_reti  input  1  pulse: RETI, immediate IME set
- instr_boundary  input  1  pulse: CPU at an opcode-fetch boundary
- dispatch_start  input  1  pulse: CPU begins interrupt dispatch
- dispatch_resolve  input  1  pulse: CPU requests the vector (PC-high push done)
- irq_pending  output  1  IME & |(IF[4:0] & IE[4:0])
- halt_wake  output  1  |(IF[4:0] & IE[4:0]), independent of IME
- ime  output  1  current IME
- vector  output  16  resolved dispatch address, registered
- vector_valid  output  1  one-cycle pulse when vector is updated

## Operation
- IF is 5 stored bits; reads return {3'b111, IF[4:0]}. IE stores and returns all 8 bits; only IE[4:0] participate in interrupt logic.
- Bit order for IF and IE: 0 vblank, 1 stat, 2 timer, 3 serial, 4 joypad. Priority: bit 0 is highest.
- Read path is combinational:
  - rdata = IF view when read_en and addr==0xFF0F.
  - rdata = IE when read_en and addr==0xFFFF.
  - rdata = 0xFF otherwise.
- Write path: writes to 0xFF0F load IF[4:0] from wdata[4:0]; writes to 0xFFFF load IE from wdata.
- Request pulses set the matching IF bit.
- Same-cycle IF conflicts: a request pulse overrides both an IF write and a dispatch clear of the same bit; the bit ends up set.
- IME control:
  - ime_di clears IME and cancels any pending EI.
  - ime_reti sets IME at the next edge.
  - ime_ei arms ei_delay. IME becomes 1 at the edge of the first instr_boundary pulse after the ime_ei cycle, and ei_delay then clears.
  - If ime_di and ime_ei arrive in the same cycle, ime_di wins.
- Dispatch FSM, states IDLE and DISPATCH:
  - IDLE + dispatch_start: IME <= 0, ei_delay <= 0, go to DISPATCH.
  - DISPATCH + dispatch_resolve: evaluate m = IF[4:0] & IE[4:0] at that cycle, including any IE write in the same cycle (the write value is used).
    - m nonzero, highest-priority index k: vector <= 0x0040 + 8*k and IF[k] cleared.
    - m zero: vector <= 0x0000 and no IF change.
    - Either case: vector_valid pulses and the FSM returns to IDLE.
  - dispatch_resolve in IDLE is ignored; dispatch_start in DISPATCH is ignored.
- irq_pending and halt_wake are combinational from registered IME, IF and IE.

## Timing
- Reset values: IF=0 (reads 0xE0), IE=0x00, IME=0, ei_delay=0, FSM=IDLE, vector=0x0000, vector_valid=0, irq_pending=0, halt_wake=0.
- Reset asserted mid-dispatch returns to IDLE with no vector_valid pulse.
- Request to flag: a pulse in cycle n is visible in IF, irq_pending and halt_wake in cycle n+1.
- Register writes take effect at the same edge as the write cycle and are visible from cycle n+1.
- EI timing:
  - ime_ei at cycle n, first instr_boundary at cycle m>n: IME=1 from cycle m+1.
  - An instr_boundary in cycle n itself does not count.
- Resolve latency: dispatch_resolve at cycle n gives vector and vector_valid=1 in cycle n+1; vector holds its value until the next resolve.
- dispatch_start at cycle n gives ime=0 in cycle n+1.

## Test plan
- Reset, then read 0xFF0F -> 0xE0; read 0xFFFF -> 0x00; read 0xFF10 -> 0xFF; ime=0; vector=0x0000.
- IE=0x04, timer_req pulse, IME=0 -> IF reads 0xE4, halt_wake=1, irq_pending=0; then ime_reti -> irq_pending=1 one cycle later.
- IF=0x1F, IE=0x1A, IME=1, dispatch_start then dispatch_resolve -> vector=0x0048, vector_valid one cycle, IF reads 0xFD, ime=0.
- Cancel case: IF=0x01, IE=0x01, dispatch_start; on the resolve cycle write IE=0x00 -> vector=0x0000, IF stays 0xE1.
- ime_ei at cycle 10 with instr_boundary also at 10 -> ime stays 0; instr_boundary at 14 -> ime=1 at 15. ime_ei then ime_di before the next boundary -> ime stays 0.
- Collision: IF bit 2 set and dispatch clears bit 2 in the same cycle timer_req pulses -> IF[2]=1 afterwards. CPU writes IF=0x00 in the same cycle as joypad_req -> IF reads 0xF0.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers, IME with delayed EI enable, and the
// dispatch handshake that resolves the highest-priority vector for the CPU.
module interrupt_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    input  logic        bus_read_en,
    input  logic        bus_write_en,
    input  logic        vblank_req,
    input  logic        stat_req,
    input  logic        timer_req,
    input  logic        serial_req,
    input  logic        joypad_req,
    input  logic        ime_ei,
    input  logic        ime_di,
    input  logic        ime_reti,
    input  logic        instr_boundary,
    input  logic        dispatch_start,
    input  logic        dispatch_resolve,
    output logic        irq_pending,
    output logic        halt_wake,
    output logic        ime,
    output logic [15:0] vector,
    output logic        vector_valid
);

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic {
        IDLE,
        DISPATCH
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic        ime_q, ime_d;
    logic        ei_delay_q, ei_delay_d;
    logic [15:0] vector_q, vector_d;
    logic        vector_valid_q, vector_valid_d;

    logic [4:0]  req;
    logic        wr_if, wr_ie;
    logic [7:0]  ie_eff;
    logic [4:0]  match;
    logic [2:0]  top_idx;
    logic        start_fire, resolve_fire;
    logic [4:0]  clear_mask;

    assign req          = {joypad_req, serial_req, timer_req, stat_req, vblank_req};
    assign wr_if        = bus_write_en && (bus_addr == ADDR_IF);
    assign wr_ie        = bus_write_en && (bus_addr == ADDR_IE);
    assign start_fire   = (state_q == IDLE) && dispatch_start;
    assign resolve_fire = (state_q == DISPATCH) && dispatch_resolve;

    // A same-cycle IE write already counts at resolve time (DMG cancel behaviour).
    assign ie_eff = wr_ie ? bus_wdata : ie_q;
    assign match  = if_q & ie_eff[4:0];

    always_comb begin
        top_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (match[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    assign clear_mask = (resolve_fire && (match != 5'd0)) ? (5'd1 << top_idx) : 5'd0;

    always_comb begin
        bus_rdata = 8'hFF;
        if (bus_read_en && (bus_addr == ADDR_IF)) begin
            bus_rdata = {3'b111, if_q};
        end else if (bus_read_en && (bus_addr == ADDR_IE)) begin
            bus_rdata = ie_q;
        end
    end

    // Request pulses are applied last so they win over writes and dispatch clears.
    always_comb begin
        if_d = wr_if ? bus_wdata[4:0] : if_q;
        if_d = if_d & ~clear_mask;
        if_d = if_d | req;
        ie_d = wr_ie ? bus_wdata : ie_q;
    end

    // Later assignments take precedence: DI beats everything, then dispatch start.
    always_comb begin
        ime_d      = ime_q;
        ei_delay_d = ei_delay_q;
        if (ei_delay_q && instr_boundary) begin
            ime_d      = 1'b1;
            ei_delay_d = 1'b0;
        end
        if (ime_ei) begin
            ei_delay_d = 1'b1;
        end
        if (ime_reti) begin
            ime_d = 1'b1;
        end
        if (start_fire) begin
            ime_d      = 1'b0;
            ei_delay_d = 1'b0;
        end
        if (ime_di) begin
            ime_d      = 1'b0;
            ei_delay_d = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dispatch_start) begin
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                if (dispatch_resolve) begin
                    state_d        = IDLE;
                    vector_valid_d = 1'b1;
                    if (match != 5'd0) begin
                        vector_d = 16'h0040 + {10'd0, top_idx, 3'd0};
                    end else begin
                        vector_d = 16'h0000;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            if_q           <= 5'd0;
            ie_q           <= 8'h00;
            ime_q          <= 1'b0;
            ei_delay_q     <= 1'b0;
            vector_q       <= 16'h0000;
            vector_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            if_q           <= if_d;
            ie_q           <= ie_d;
            ime_q          <= ime_d;
            ei_delay_q     <= ei_delay_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
        end
    end

    assign halt_wake    = |(if_q & ie_q[4:0]);
    assign irq_pending  = ime_q & halt_wake;
    assign ime          = ime_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: one task per feature, inline checks
// against hand-computed values.
module tb_interrupt_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_read_en;
    logic        bus_write_en;
    logic        vblank_req, stat_req, timer_req, serial_req, joypad_req;
    logic        ime_ei, ime_di, ime_reti, instr_boundary;
    logic        dispatch_start, dispatch_resolve;
    logic        irq_pending, halt_wake, ime;
    logic [15:0] vector;
    logic        vector_valid;

    int tests;
    int fails;
    logic [7:0] rd;

    interrupt_controller dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_read_en      (bus_read_en),
        .bus_write_en     (bus_write_en),
        .vblank_req       (vblank_req),
        .stat_req         (stat_req),
        .timer_req        (timer_req),
        .serial_req       (serial_req),
        .joypad_req       (joypad_req),
        .ime_ei           (ime_ei),
        .ime_di           (ime_di),
        .ime_reti         (ime_reti),
        .instr_boundary   (instr_boundary),
        .dispatch_start   (dispatch_start),
        .dispatch_resolve (dispatch_resolve),
        .irq_pending      (irq_pending),
        .halt_wake        (halt_wake),
        .ime              (ime),
        .vector           (vector),
        .vector_valid     (vector_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_addr = 16'h0000; bus_wdata = 8'h00;
        bus_read_en = 1'b0; bus_write_en = 1'b0;
        vblank_req = 1'b0; stat_req = 1'b0; timer_req = 1'b0;
        serial_req = 1'b0; joypad_req = 1'b0;
        ime_ei = 1'b0; ime_di = 1'b0; ime_reti = 1'b0; instr_boundary = 1'b0;
        dispatch_start = 1'b0; dispatch_resolve = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_write_en = 1'b1;
        tick();
        bus_write_en = 1'b0; bus_addr = 16'h0000; bus_wdata = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus_addr = a; bus_read_en = 1'b1;
        #1;
        d = bus_rdata;
        bus_read_en = 1'b0; bus_addr = 16'h0000;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #12;
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hE0) begin fails++; $display("[TB] FAIL reset_if: got %h expected e0", rd); end
        bus_read(16'hFFFF, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("[TB] FAIL reset_ie: got %h expected 00", rd); end
        bus_read(16'hFF10, rd);
        tests++; if (rd !== 8'hFF) begin fails++; $display("[TB] FAIL reset_other: got %h expected ff", rd); end
        bus_addr = 16'hFF0F; #1;
        tests++; if (bus_rdata !== 8'hFF) begin fails++; $display("[TB] FAIL noread_en: got %h expected ff", bus_rdata); end
        bus_addr = 16'h0000;
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL reset_ime: got %b expected 0", ime); end
        tests++; if (vector !== 16'h0000) begin fails++; $display("[TB] FAIL reset_vector: got %h expected 0000", vector); end
        tests++; if ({vector_valid, irq_pending, halt_wake} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {vector_valid, irq_pending, halt_wake});
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_request_wake();
        bus_write(16'hFFFF, 8'h04);
        timer_req = 1'b1;
        tick();
        timer_req = 1'b0;
        tests++; if ({halt_wake, irq_pending} !== 2'b10) begin
            fails++; $display("[TB] FAIL timer_wake: got %b expected 10", {halt_wake, irq_pending});
        end
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hE4) begin fails++; $display("[TB] FAIL timer_if: got %h expected e4", rd); end
        ime_reti = 1'b1;
        tick();
        ime_reti = 1'b0;
        tests++; if ({ime, irq_pending} !== 2'b11) begin
            fails++; $display("[TB] FAIL reti_pending: got %b expected 11", {ime, irq_pending});
        end
    endtask

    task automatic test_dispatch();
        bus_write(16'hFF0F, 8'h1F);
        bus_write(16'hFFFF, 8'h1A);
        dispatch_start = 1'b1;
        tick();
        dispatch_start = 1'b0;
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL start_ime: got %b expected 0", ime); end
        tests++; if (vector_valid !== 1'b0) begin fails++; $display("[TB] FAIL start_valid: got %b expected 0", vector_valid); end
        dispatch_resolve = 1'b1;
        tick();
        dispatch_resolve = 1'b0;
        tests++; if ({vector_valid, vector} !== {1'b1, 16'h0048}) begin
            fails++; $display("[TB] FAIL dispatch_vec: got %b/%h expected 1/0048", vector_valid, vector);
        end
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hFD) begin fails++; $display("[TB] FAIL dispatch_if: got %h expected fd", rd); end
        tick();
        tests++; if ({vector_valid, vector} !== {1'b0, 16'h0048}) begin
            fails++; $display("[TB] FAIL valid_pulse: got %b/%h expected 0/0048", vector_valid, vector);
        end
        dispatch_resolve = 1'b1;
        tick();
        dispatch_resolve = 1'b0;
        tests++; if (vector_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_resolve: got %b expected 0", vector_valid); end
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hFD) begin fails++; $display("[TB] FAIL idle_resolve_if: got %h expected fd", rd); end
    endtask

    task automatic test_cancel();
        bus_write(16'hFF0F, 8'h01);
        bus_write(16'hFFFF, 8'h01);
        dispatch_start = 1'b1;
        tick();
        dispatch_start = 1'b0;
        dispatch_resolve = 1'b1;
        bus_addr = 16'hFFFF; bus_wdata = 8'h00; bus_write_en = 1'b1;
        tick();
        clear_inputs();
        tests++; if ({vector_valid, vector} !== {1'b1, 16'h0000}) begin
            fails++; $display("[TB] FAIL cancel_vec: got %b/%h expected 1/0000", vector_valid, vector);
        end
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hE1) begin fails++; $display("[TB] FAIL cancel_if: got %h expected e1", rd); end
        bus_read(16'hFFFF, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("[TB] FAIL cancel_ie: got %h expected 00", rd); end
    endtask

    task automatic test_ei_timing();
        ime_ei = 1'b1; instr_boundary = 1'b1;
        tick();
        ime_ei = 1'b0; instr_boundary = 1'b0;
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL ei_same_boundary: got %b expected 0", ime); end
        tick(); tick(); tick();
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL ei_waiting: got %b expected 0", ime); end
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tests++; if (ime !== 1'b1) begin fails++; $display("[TB] FAIL ei_boundary: got %b expected 1", ime); end
        ime_di = 1'b1;
        tick();
        ime_di = 1'b0;
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL di_clear: got %b expected 0", ime); end
        ime_ei = 1'b1;
        tick();
        ime_ei = 1'b0; ime_di = 1'b1;
        tick();
        ime_di = 1'b0; instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL di_cancels_ei: got %b expected 0", ime); end
        ime_ei = 1'b1; ime_di = 1'b1;
        tick();
        ime_ei = 1'b0; ime_di = 1'b0; instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tests++; if (ime !== 1'b0) begin fails++; $display("[TB] FAIL di_beats_ei: got %b expected 0", ime); end
    endtask

    task automatic test_collision();
        bus_write(16'hFF0F, 8'h04);
        bus_write(16'hFFFF, 8'h04);
        dispatch_start = 1'b1;
        tick();
        dispatch_start = 1'b0;
        dispatch_resolve = 1'b1; timer_req = 1'b1;
        tick();
        dispatch_resolve = 1'b0; timer_req = 1'b0;
        tests++; if (vector !== 16'h0050) begin fails++; $display("[TB] FAIL collide_vec: got %h expected 0050", vector); end
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hE4) begin fails++; $display("[TB] FAIL collide_clear: got %h expected e4", rd); end
        bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_write_en = 1'b1; joypad_req = 1'b1;
        tick();
        clear_inputs();
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hF0) begin fails++; $display("[TB] FAIL collide_write: got %h expected f0", rd); end
    endtask

    task automatic test_back_to_back();
        bus_write(16'hFF0F, 8'h18);
        bus_write(16'hFFFF, 8'h1F);
        dispatch_start = 1'b1;
        tick();
        dispatch_start = 1'b0; dispatch_resolve = 1'b1;
        tick();
        dispatch_resolve = 1'b0; dispatch_start = 1'b1;
        tests++; if (vector !== 16'h0058) begin fails++; $display("[TB] FAIL b2b_first: got %h expected 0058", vector); end
        tick();
        dispatch_start = 1'b0; dispatch_resolve = 1'b1;
        tick();
        dispatch_resolve = 1'b0;
        tests++; if ({vector_valid, vector} !== {1'b1, 16'h0060}) begin
            fails++; $display("[TB] FAIL b2b_second: got %b/%h expected 1/0060", vector_valid, vector);
        end
        bus_read(16'hFF0F, rd);
        tests++; if (rd !== 8'hE0) begin fails++; $display("[TB] FAIL b2b_if: got %h expected e0", rd); end
        tests++; if (halt_wake !== 1'b0) begin fails++; $display("[TB] FAIL b2b_wake: got %b expected 0", halt_wake); end
    endtask

    task automatic test_reset_mid_dispatch();
        bus_write(16'hFF0F, 8'h01);
        bus_write(16'hFFFF, 8'h01);
        dispatch_start = 1'b1;
        tick();
        dispatch_start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if ({vector_valid, vector, ime} !== {1'b0, 16'h0000, 1'b0}) begin
            fails++; $display("[TB] FAIL midreset_out: got %b/%h/%b expected 0/0000/0", vector_valid, vector, ime);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        dispatch_resolve = 1'b1;
        tick();
        dispatch_resolve = 1'b0;
        tests++; if (vector_valid !== 1'b0) begin fails++; $display("[TB] FAIL midreset_idle: got %b expected 0", vector_valid); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_request_wake();
        test_dispatch();
        test_cancel();
        test_ei_timing();
        test_collision();
        test_back_to_back();
        test_reset_mid_dispatch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
